// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchroniser and centre sampling.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote of rx_s at terminal count -2/-1/0.
module uart_rx #(
  parameter int unsigned BAUD_TICKS = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [15:0] BAUD_TC = 16'(BAUD_TICKS - 1);
  localparam logic [15:0] HALF_TC = 16'((BAUD_TICKS / 2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic        rx_s_d_q;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        sample;

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic rx_s_dd_q;

  // rx_s_d_q and rx_s_dd_q hold rx_s from terminal count -1 and -2
  assign sample = (rx_s_dd_q & rx_s_d_q) | (rx_s_dd_q & rx_s) | (rx_s_d_q & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s_dd_q <= 1'b1;
    end else begin
      rx_s_dd_q <= rx_s_d_q;
    end
  end
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      rx_s_d_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], rx_in};
      rx_s_d_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_s_d_q && !rx_s) begin
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_q == HALF_TC) begin
          if (sample) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            baud_d  = '0;
            bit_d   = '0;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_TC) begin
          shift_d = {sample, shift_q[7:1]};
          baud_d  = '0;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_TC) begin
          baud_d = '0;
          // leave at the stop-bit centre so a following start edge is not missed
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = (state_q != IDLE);

endmodule
